// File: rtl/id_decode_sequencer.sv
// ID-stage decode sequencer: fetch handshake, one-shot decoder start, watchdog-guarded
// wait for decode completion, and execute-side handshake, with stall, flush and abort control.
module id_decode_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        soc_clk,
    input  logic        ID_reset,
    input  logic        ID_stall,
    input  logic        ID_flush,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    output logic        fetch_ready,
    output logic        dec_start,
    output logic [31:0] dec_instr,
    output logic        dec_abort,
    input  logic        dec_done,
    input  logic        dec_invalid,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic        ex_invalid,
    output logic        timeout_err,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  wd_cnt_r;
    logic [31:0] instr_r;
    logic        ex_invalid_r;
    logic        timeout_err_r;
    logic [15:0] count_r;

    logic        run_s;
    logic        fetch_ready_s;
    logic        dec_start_s;
    logic        dec_abort_s;
    logic        ex_valid_s;
    logic        ex_hs_s;
    logic        fetch_hs_s;

    // Handshake strobes decoded from the registered state; flush and stall both mask them.
    always_comb begin
        run_s         = !ID_flush && !ID_stall;
        fetch_ready_s = 1'b0;
        dec_start_s   = 1'b0;
        dec_abort_s   = 1'b0;
        ex_valid_s    = 1'b0;
        case (state_r)
            IDLE: begin
                fetch_ready_s = run_s;
            end
            ISSUE: begin
                dec_start_s = run_s;
                dec_abort_s = ID_flush;
            end
            WAIT: begin
                dec_abort_s = ID_flush;
            end
            HOLD: begin
                ex_valid_s    = run_s;
                fetch_ready_s = run_s && ex_ready;
            end
            default: begin
                fetch_ready_s = 1'b0;
            end
        endcase
        ex_hs_s    = ex_valid_s && ex_ready;
        fetch_hs_s = fetch_ready_s && fetch_valid;
    end

    // Sequencer FSM with watchdog, captured instruction, result flags and handshake counter.
    always_ff @(posedge soc_clk or posedge ID_reset) begin
        if (ID_reset) begin
            state_r       <= IDLE;
            wd_cnt_r      <= 8'd0;
            instr_r       <= 32'd0;
            ex_invalid_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            count_r       <= 16'd0;
        end else if (ID_flush) begin
            state_r      <= IDLE;
            wd_cnt_r     <= 8'd0;
            ex_invalid_r <= 1'b0;
        end else if (!ID_stall) begin
            if (ex_hs_s) begin
                count_r <= count_r + 16'd1;
            end
            if (fetch_hs_s) begin
                instr_r <= fetch_instr;
            end
            case (state_r)
                IDLE: begin
                    if (fetch_hs_s) begin
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt_r <= 8'd0;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    // A completion in the watchdog's last cycle still counts as a real result.
                    if (dec_done) begin
                        ex_invalid_r <= dec_invalid;
                        state_r      <= HOLD;
                    end else if (wd_cnt_r == WD_LAST) begin
                        ex_invalid_r  <= 1'b1;
                        timeout_err_r <= 1'b1;
                        state_r       <= HOLD;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 8'd1;
                    end
                end
                HOLD: begin
                    if (ex_ready) begin
                        state_r <= fetch_valid ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fetch_ready = fetch_ready_s;
    assign dec_start   = dec_start_s;
    assign dec_abort   = dec_abort_s;
    assign ex_valid    = ex_valid_s;
    assign dec_instr   = instr_r;
    assign ex_invalid  = ex_invalid_r;
    assign timeout_err = timeout_err_r;
    assign instr_count = count_r;

endmodule
